// File: rtl/store_align.sv
// Store byte-lane aligner: turns (addr, data, funct3) into word-aligned write beats with byte enables.
// Optional MISALIGNED_SPLIT_EN splits misaligned SH/SW into two beats; otherwise they fault.
module store_align (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_type,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_we,
    output logic        fault,
    output logic        busy
);

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, FAULT = 2'd2, BEAT1 = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, FAULT = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  we_q, we_d;
    logic        vld_q, fault_q, busy_q;
`ifdef MISALIGNED_SPLIT_EN
    logic [31:0] b1_wdata_q, b1_wdata_d;
    logic [3:0]  b1_we_q, b1_we_d;
    logic        split_q, split_d;
`endif

    logic [1:0]  off;
    logic [31:0] data_m;
    logic [3:0]  we_base;
    logic        illegal, misaligned, to_fault, final_beat, accept;

    assign off = req_addr[1:0];

    // Unused upper bytes are masked off so disabled lanes always carry zero.
    always_comb begin
        data_m  = '0;
        we_base = '0;
        illegal = 1'b0;
        case (req_type)
            3'b000:  begin data_m = {24'b0, req_data[7:0]};  we_base = 4'b0001; end
            3'b001:  begin data_m = {16'b0, req_data[15:0]}; we_base = 4'b0011; end
            3'b010:  begin data_m = req_data;                we_base = 4'b1111; end
            default: illegal = 1'b1;
        endcase
    end

    assign misaligned = ((req_type == 3'b001) && (off == 2'b11)) ||
                        ((req_type == 3'b010) && (off != 2'b00));

`ifdef MISALIGNED_SPLIT_EN
    assign to_fault   = illegal;
    assign final_beat = (state_q == BEAT1) || ((state_q == BEAT0) && !split_q);
`else
    assign to_fault   = illegal || misaligned;
    assign final_beat = (state_q == BEAT0);
`endif

    assign req_ready = (state_q == IDLE) || (final_beat && dmem_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
`ifdef MISALIGNED_SPLIT_EN
        b1_wdata_d = b1_wdata_q;
        b1_we_d    = b1_we_q;
        split_d    = split_q;
`endif
        if (accept) begin
            if (to_fault) begin
                state_d = FAULT;
            end else begin
                state_d = BEAT0;
                addr_d  = {req_addr[31:2], 2'b00};
                wdata_d = data_m << {off, 3'b000};
                we_d    = we_base << off;
`ifdef MISALIGNED_SPLIT_EN
                // Second-half lanes are what spilled past bit 31 of the first beat.
                b1_wdata_d = data_m >> (6'd32 - {1'b0, off, 3'b000});
                b1_we_d    = we_base >> (3'd4 - {1'b0, off});
                split_d    = misaligned;
`endif
            end
        end else begin
            case (state_q)
                BEAT0: if (dmem_ready) begin
`ifdef MISALIGNED_SPLIT_EN
                    if (split_q) begin
                        state_d = BEAT1;
                        addr_d  = addr_q + 32'd4;
                        wdata_d = b1_wdata_q;
                        we_d    = b1_we_q;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
`ifdef MISALIGNED_SPLIT_EN
                BEAT1: if (dmem_ready) state_d = IDLE;
`endif
                FAULT:   state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            vld_q      <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            b1_wdata_q <= '0;
            b1_we_q    <= '0;
            split_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            vld_q      <= (state_d != IDLE) && (state_d != FAULT);
            fault_q    <= (state_d == FAULT);
            busy_q     <= (state_d != IDLE);
`ifdef MISALIGNED_SPLIT_EN
            b1_wdata_q <= b1_wdata_d;
            b1_we_q    <= b1_we_d;
            split_q    <= split_d;
`endif
        end
    end

    assign dmem_valid = vld_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_we    = we_q;
    assign fault      = fault_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_store_align.sv
// Bench for store_align: directed literal cases plus random traffic checked against a byte-level store model.
module tb_store_align;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, dmem_valid, dmem_ready, fault, busy;
    logic [31:0] req_addr, req_data, dmem_addr, dmem_wdata;
    logic [2:0]  req_type;
    logic [3:0]  dmem_we;

    store_align dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_type(req_type),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  e;
    } beat_t;

    beat_t mq[$];
    bit    m_fault = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Walks the stored bytes one at a time; every new word address starts a new beat.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        beat_t       b[2];
        int          n, cnt, lane;
        logic [31:0] ba, w;
        if (t > 3'd2) begin
            m_fault = 1'b1;
            return;
        end
        n   = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : 4;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            ba   = a + k;
            w    = {ba[31:2], 2'b00};
            lane = int'(ba[1:0]);
            if (cnt == 0 || b[cnt-1].a != w) begin
                b[cnt] = {w, 32'h0, 4'h0};
                cnt++;
            end
            b[cnt-1].d[lane*8 +: 8] = d[k*8 +: 8];
            b[cnt-1].e[lane]        = 1'b1;
        end
`ifdef MISALIGNED_SPLIT_EN
        for (int i = 0; i < cnt; i++) mq.push_back(b[i]);
`else
        if (cnt == 2) m_fault = 1'b1;
        else mq.push_back(b[0]);
`endif
    endtask

    always @(negedge clk) begin
        logic exp_rdy;
        if (chk_en) begin
            exp_rdy = !m_fault && (mq.size() == 0 || (mq.size() == 1 && dmem_ready));
            chk("m_valid", dmem_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("m_addr", dmem_addr, mq[0].a);
                chk("m_wdata", dmem_wdata, mq[0].d);
                chk("m_we", dmem_we, mq[0].e);
            end
            chk("m_fault", fault, m_fault);
            chk("m_busy", busy, m_fault || mq.size() != 0);
            chk("m_ready", req_ready, exp_rdy);
            if (rst) begin
                mq.delete();
                m_fault = 1'b0;
            end else begin
                m_fault = 1'b0;
                if (mq.size() != 0 && dmem_ready) void'(mq.pop_front());
                if (req_valid && exp_rdy) model_accept(req_addr, req_data, req_type);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_type  = t;
    endtask

    task automatic beat_is(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
        chk({nm, "_valid"}, dmem_valid, 1'b1);
        chk({nm, "_addr"}, dmem_addr, a);
        chk({nm, "_wdata"}, dmem_wdata, d);
        chk({nm, "_we"}, dmem_we, e);
    endtask

    initial begin
        model_accept(32'h0000_1003, 32'hDEAD_BEEF, 3'b000);
        chk("model_sb_cnt", mq.size(), 1);
        chk("model_sb_wdata", mq[0].d, 32'hEF00_0000);
        chk("model_sb_we", mq[0].e, 4'b1000);
        mq.delete();
        model_accept(32'h0000_3001, 32'h1122_3344, 3'b010);
`ifdef MISALIGNED_SPLIT_EN
        chk("model_sw_cnt", mq.size(), 2);
        chk("model_sw_b1", mq[1].d, 32'h0000_0011);
`else
        chk("model_sw_fault", m_fault, 1'b1);
`endif
        mq.delete();
        m_fault = 1'b0;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_type = '0; dmem_ready = 1'b1;
        tick;
        chk_en = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", dmem_valid, 1'b0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_we", dmem_we, 4'h0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        tick;

        // SB, then an aligned SW accepted on the same edge the SB beat completes.
        put(32'h0000_1003, 32'hDEAD_BEEF, 3'b000);
        tick;
        put(32'h0000_4000, 32'h5566_7788, 3'b010);
        @(negedge clk);
        beat_is("sb", 32'h0000_1000, 32'hEF00_0000, 4'b1000);
        chk("sb_b2b_ready", req_ready, 1'b1);
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        beat_is("sw_al", 32'h0000_4000, 32'h5566_7788, 4'b1111);
        tick;
        @(negedge clk);
        chk("sw_al_done", dmem_valid, 1'b0);
        tick;

        // SH held under backpressure.
        put(32'h0000_2002, 32'h0000_CAFE, 3'b001);
        dmem_ready = 1'b0;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            beat_is("sh_hold", 32'h0000_2000, 32'hCAFE_0000, 4'b1100);
            chk("sh_hold_ready", req_ready, 1'b0);
            tick;
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        beat_is("sh_rel", 32'h0000_2000, 32'hCAFE_0000, 4'b1100);
        tick;
        @(negedge clk);
        chk("sh_done", dmem_valid, 1'b0);
        tick;

        // Misaligned SW, then misaligned SH wrapping past the top of memory.
        put(32'h0000_3001, 32'h1122_3344, 3'b010);
        tick;
        req_valid = 1'b0;
        @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
        beat_is("sw_b0", 32'h0000_3000, 32'h2233_4400, 4'b1110);
        chk("sw_b0_ready", req_ready, 1'b0);
        tick;
        @(negedge clk);
        beat_is("sw_b1", 32'h0000_3004, 32'h0000_0011, 4'b0001);
        tick;
`else
        chk("sw_mis_fault", fault, 1'b1);
        chk("sw_mis_valid", dmem_valid, 1'b0);
        chk("sw_mis_ready", req_ready, 1'b0);
        tick;
        @(negedge clk);
        chk("sw_mis_fault_end", fault, 1'b0);
`endif
        put(32'hFFFF_FFFF, 32'h0000_ABCD, 3'b001);
        tick;
        req_valid = 1'b0;
        @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
        beat_is("sh_wrap_b0", 32'hFFFF_FFFC, 32'hCD00_0000, 4'b1000);
        tick;
        @(negedge clk);
        beat_is("sh_wrap_b1", 32'h0000_0000, 32'h0000_00AB, 4'b0001);
        tick;
`else
        chk("sh_wrap_fault", fault, 1'b1);
        chk("sh_wrap_valid", dmem_valid, 1'b0);
        tick;
`endif

        // Illegal funct3.
        put(32'h0000_0040, 32'h1234_5678, 3'b011);
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        chk("ill_fault", fault, 1'b1);
        chk("ill_valid", dmem_valid, 1'b0);
        chk("ill_ready", req_ready, 1'b0);
        tick;
        @(negedge clk);
        chk("ill_fault_end", fault, 1'b0);
        chk("ill_ready_end", req_ready, 1'b1);
        tick;

        // Reset while a beat is pending (second half when splitting).
`ifdef MISALIGNED_SPLIT_EN
        put(32'h0000_5002, 32'hA1B2_C3D4, 3'b010);
        tick;
        req_valid = 1'b0;
        tick;
`else
        put(32'h0000_5000, 32'hA1B2_C3D4, 3'b010);
        tick;
        req_valid = 1'b0;
`endif
        rst = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("rstmid_pending", dmem_valid, 1'b1);
        chk("rstmid_addr", dmem_addr, 32'h0000_5004 - `ifdef MISALIGNED_SPLIT_EN 32'h0 `else 32'h4 `endif);
        tick;
        rst = 1'b0;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", dmem_valid, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_ready", req_ready, 1'b1);
        tick;
        @(negedge clk);
        chk("rstmid_quiet", dmem_valid, 1'b0);
        tick;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            int          tsel;
            rst        = ($urandom_range(0, 399) == 0);
            req_valid  = ($urandom_range(0, 9) < 6);
            dmem_ready = ($urandom_range(0, 9) < 7);
            a          = $urandom;
            if ($urandom_range(0, 3) == 0) a = {30'h3FFF_FFFF, a[1:0]};
            req_addr   = a;
            req_data   = $urandom;
            tsel       = $urandom_range(0, 9);
            req_type   = (tsel < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            tick;
        end
        rst = 1'b0;
        req_valid = 1'b0;
        dmem_ready = 1'b1;
        repeat (4) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
